// File: rtl/activation_pipe_pkg.sv
// rtl/activation_pipe_pkg.sv - shared types, constants and helpers for the activation pipeline
package activation_pipe_pkg;

    typedef struct packed {
        logic        sgn;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_24_8;

    typedef enum logic [1:0] {
        ACT_SIGMOID = 2'd0,
        ACT_RELU    = 2'd1,
        ACT_LEAKY   = 2'd2,
        ACT_PASS    = 2'd3
    } act_mode_t;

    localparam int EXP_BIAS = 127;
    localparam int FX_W     = 25;  // unsigned Q1.24
    localparam int A_W      = 28;  // unsigned Q4.24, saturating magnitude

    localparam logic [A_W-1:0]  A_BP_1    = 28'h100_0000;  // 1.0
    localparam logic [A_W-1:0]  A_BP_2    = 28'h260_0000;  // 2.375
    localparam logic [A_W-1:0]  A_BP_5    = 28'h500_0000;  // 5.0
    localparam logic [FX_W-1:0] FX_ONE    = 25'h100_0000;
    localparam logic [FX_W-1:0] OFF_SEG0  = 25'h080_0000;  // 0.5
    localparam logic [FX_W-1:0] OFF_SEG1  = 25'h0A0_0000;  // 0.625
    localparam logic [FX_W-1:0] OFF_SEG2  = 25'h0D8_0000;  // 0.84375
    localparam logic [31:0]     FLOAT_ONE = 32'h3F80_0000;

    // |x| in Q4.24; values of 8.0 and above (including inf/NaN) saturate.
    function automatic logic [A_W-1:0] float_mag_fx(input float_24_8 x);
        logic [A_W-1:0] m;
        m = {4'b0000, 1'b1, x.man};
        if (x.exp == 8'd0) begin
            return '0;
        end else if (x.exp >= 8'(EXP_BIAS + 3)) begin
            return '1;
        end else if (x.exp >= 8'(EXP_BIAS - 1)) begin
            return m << (x.exp - 8'(EXP_BIAS - 1));
        end else begin
            return m >> (8'(EXP_BIAS - 1) - x.exp);
        end
    endfunction

endpackage

// File: rtl/activation_pipe_lane.sv
// rtl/activation_pipe_lane.sv - per-lane activation datapath, split around the stage-1 register
module act_lane
    import activation_pipe_pkg::*;
#(
    parameter int LEAKY_SHIFT = 3
) (
    input  logic [31:0] x,
    input  act_mode_t   mode,
    output logic [31:0] mid,
    input  logic [31:0] mid_q,
    input  act_mode_t   mode_q,
    output logic [31:0] y
);

    localparam logic [7:0] LS = 8'(LEAKY_SHIFT);

    float_24_8         xf;
    logic [A_W-1:0]    a;
    logic [FX_W-1:0]   f;
    logic [FX_W-1:0]   sig;
    logic [FX_W-1:0]   r;
    logic [FX_W-1:0]   norm;
    logic [4:0]        msb;
    logic              found;

    assign xf = x;

    // Stage 1: sigmoid leaves an unsigned Q1.24 value in mid; other modes finish here.
    always_comb begin
        a   = float_mag_fx(xf);
        f   = FX_ONE;
        mid = x;
        if (a >= A_BP_5) begin
            f = FX_ONE;
        end else if (a >= A_BP_2) begin
            f = OFF_SEG2 + FX_W'(a >> 5);
        end else if (a >= A_BP_1) begin
            f = OFF_SEG1 + FX_W'(a >> 3);
        end else begin
            f = OFF_SEG0 + FX_W'(a >> 2);
        end
        sig = xf.sgn ? (FX_ONE - f) : f;
        case (mode)
            ACT_SIGMOID: mid = {7'd0, sig};
            ACT_RELU:    mid = xf.sgn ? 32'd0 : x;
            ACT_LEAKY: begin
                if (!xf.sgn || xf.exp == 8'hFF) begin
                    mid = x;
                end else if (xf.exp <= LS) begin
                    mid = 32'd0;
                end else begin
                    mid = {1'b1, xf.exp - LS, xf.man};
                end
            end
            default:     mid = x;
        endcase
    end

    // Stage 2: normalise the Q1.24 sigmoid value, truncating below the mantissa LSB.
    always_comb begin
        r     = mid_q[FX_W-1:0];
        msb   = 5'd0;
        found = 1'b0;
        for (int i = 0; i < FX_W; i++) begin
            if (r[i]) begin
                msb   = 5'(i);
                found = 1'b1;
            end
        end
        norm = r << (5'd24 - msb);
        y    = mid_q;
        if (mode_q == ACT_SIGMOID) begin
            y = found ? {1'b0, 8'd103 + {3'd0, msb}, norm[23:1]} : 32'd0;
        end
    end

endmodule

// File: rtl/activation_pipe.sv
// rtl/activation_pipe.sv - two-stage multi-lane activation unit with valid/ready handshake
module activation_pipe
    import activation_pipe_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int LEAKY_SHIFT = 3,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic                  in_last,
    input  logic [LANES*32-1:0]   data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [LANES*32-1:0]   data_out,
    output logic [CNT_W-1:0]      beat_count
);

    logic                s1_valid;
    logic                s1_last;
    act_mode_t           s1_mode;
    logic [LANES*32-1:0] s1_word;
    logic [LANES*32-1:0] mid_all;
    logic [LANES*32-1:0] y_all;
    act_mode_t           mode_in;
    logic                advance;

    assign mode_in  = act_mode_t'(in_mode);
    // Whole pipe moves together: stage 2 free or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(.LEAKY_SHIFT(LEAKY_SHIFT)) u_lane (
            .x      (data_in[g*32 +: 32]),
            .mode   (mode_in),
            .mid    (mid_all[g*32 +: 32]),
            .mid_q  (s1_word[g*32 +: 32]),
            .mode_q (s1_mode),
            .y      (y_all[g*32 +: 32])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_mode    <= ACT_SIGMOID;
            s1_word    <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            data_out   <= '0;
            beat_count <= '0;
        end else begin
            if (advance) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    s1_last <= in_last;
                    s1_mode <= mode_in;
                    s1_word <= mid_all;
                end
                if (s1_valid) begin
                    out_last <= s1_last;
                    data_out <= y_all;
                end
            end
            if (in_valid && in_ready && beat_count != '1) begin
                beat_count <= beat_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_activation_pipe.sv
// tb/tb_activation_pipe.sv - scoreboard bench for activation_pipe
module tb_activation_pipe;
    import activation_pipe_pkg::*;

    localparam int LANES = 4;
    localparam int W     = LANES * 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic          in_last;
    logic [W-1:0]  data_in;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [W-1:0]  data_out;
    logic [15:0]   beat_count;

    logic          s_in_valid;
    logic          s_in_ready;
    logic          s_out_valid;
    logic          s_out_last;
    logic [W-1:0]  s_data_out;
    logic [3:0]    s_beat_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_last;

    always #5 clk = ~clk;

    activation_pipe #(.LANES(LANES), .LEAKY_SHIFT(3), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_last    (in_last),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .data_out   (data_out),
        .beat_count (beat_count)
    );

    activation_pipe #(.LANES(LANES), .LEAKY_SHIFT(3), .CNT_W(4)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_mode    (2'd3),
        .in_last    (1'b0),
        .data_in    (data_in),
        .out_valid  (s_out_valid),
        .out_ready  (1'b1),
        .out_last   (s_out_last),
        .data_out   (s_data_out),
        .beat_count (s_beat_count)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
    task automatic send(input logic [W-1:0] d, input logic [1:0] m, input logic l,
                        input logic [W-1:0] e);
        int n;
        in_valid = 1'b1;
        data_in  = d;
        in_mode  = m;
        in_last  = l;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk);
            #1;
        end
        if (n == 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, want 1", n);
        end
        @(posedge clk);
        #1;
        sb_q.push_back('{data: e, last: l});
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 40 && sb_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", W'(sb_q.size()), W'(0));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("in_ready_rule", W'(in_ready), W'(!out_valid || out_ready));
            if (prev_stall) begin
                check("hold_valid", W'(out_valid), W'(1));
                check("hold_data", data_out, prev_data);
                check("hold_last", W'(out_last), W'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data %h with empty scoreboard", data_out);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("beat_data", data_out, mon_e.data);
                    check("beat_last", W'(out_last), W'(mon_e.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = data_out;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        prev_stall = 1'b0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_mode    = 2'd0;
        in_last    = 1'b0;
        data_in    = '0;
        out_ready  = 1'b1;
        s_in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_data_out", data_out, W'(0));
        check("rst_out_last", W'(out_last), W'(0));
        check("rst_beat_count", W'(beat_count), W'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", W'(in_ready), W'(1));

        // Sigmoid basic vector plus exact 2-cycle latency
        send(pack4(32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4080_0000), 2'd0, 1'b1,
             pack4(32'h3F00_0000, 32'h3F40_0000, 32'h3E80_0000, 32'h3F78_0000));
        check("lat_stage1", W'(out_valid), W'(0));
        @(posedge clk);
        #1;
        check("lat_stage2", W'(out_valid), W'(1));
        check("count_one", W'(beat_count), W'(1));

        // Sigmoid saturation, segment boundaries, relu, leaky, pass back to back
        send(pack4(32'h40C0_0000, 32'hC0C0_0000, 32'h7F80_0000, 32'hFF80_0000), 2'd0, 1'b0,
             pack4(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000));
        send(pack4(32'h3F00_0000, 32'h4018_0000, 32'hC020_0000, 32'h40A0_0000), 2'd0, 1'b0,
             pack4(32'h3F20_0000, 32'h3F6B_0000, 32'h3DA0_0000, 32'h3F80_0000));
        send(pack4(32'hC040_0000, 32'h4000_0000, 32'h8000_0000, 32'h7FC0_0001), 2'd1, 1'b0,
             pack4(32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 32'h7FC0_0001));
        send(pack4(32'hC000_0000, 32'h8080_0000, 32'hFF80_0000, 32'h3F80_0000), 2'd2, 1'b0,
             pack4(32'hBE80_0000, 32'h0000_0000, 32'hFF80_0000, 32'h3F80_0000));
        send(pack4(32'hFFC1_2345, 32'h0000_0001, 32'h8000_0000, 32'h1234_5678), 2'd3, 1'b1,
             pack4(32'hFFC1_2345, 32'h0000_0001, 32'h8000_0000, 32'h1234_5678));
        drain();
        check("count_six", W'(beat_count), W'(6));

        // Backpressure: out_ready low for cycles 3..7 of a 6-beat stream
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(pack4(32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
                               32'h3000_0000 + 32'(i), 32'h4000_0000 + 32'(i)),
                         2'd3, (i == 5),
                         pack4(32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
                               32'h3000_0000 + 32'(i), 32'h4000_0000 + 32'(i)));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("count_twelve", W'(beat_count), W'(12));

        // Reset with two beats in flight
        send(pack4(32'h1, 32'h2, 32'h3, 32'h4), 2'd3, 1'b0, pack4(32'h1, 32'h2, 32'h3, 32'h4));
        send(pack4(32'h5, 32'h6, 32'h7, 32'h8), 2'd3, 1'b1, pack4(32'h5, 32'h6, 32'h7, 32'h8));
        #2 reset = 1'b0;
        #1;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_count", W'(beat_count), W'(0));
        sb_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_idle", W'(out_valid), W'(0));
        @(posedge clk);
        #1;
        send(pack4(32'hC000_0000, 32'h4000_0000, 32'h0, 32'h0), 2'd2, 1'b1,
             pack4(32'hBE80_0000, 32'h4000_0000, 32'h0, 32'h0));
        drain();
        check("midrst_count_after", W'(beat_count), W'(1));

        // Saturating counter on the CNT_W=4 instance
        s_in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("sat_count_10", W'(s_beat_count), W'(10));
        repeat (10) @(posedge clk);
        #1;
        check("sat_count_20", W'(s_beat_count), W'(15));
        s_in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
